// File: rtl/lzc_norm_pipe_pkg.sv
// Shared constants and helpers for the leading-zero / leading-sign normaliser.
package lzc_norm_pipe_pkg;

    localparam int   EXP_W_DEF     = 8;
    localparam logic LZC_MODE_ZERO = 1'b0;
    localparam logic LZC_MODE_SIGN = 1'b1;

    // Count width able to hold the value WIDTH itself (all-zero input).
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/lzc_norm_pipe_if.sv
// Valid/ready bundle for the normaliser: beat in on the in_* side, normalised result out on the out_* side.
interface lzc_norm_pipe_if
    import lzc_norm_pipe_pkg::*;
#(
    parameter int WIDTH = 24,
    parameter int EXP_W = EXP_W_DEF
);
    localparam int CNT_W = cnt_w(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_mant;
    logic [EXP_W-1:0] in_exp;
    logic             in_sign_md;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_mant;
    logic [CNT_W-1:0] out_cnt;
    logic [EXP_W-1:0] out_exp;
    logic             out_zero;
    logic             out_uflow;

    modport master (
        output in_valid, in_mant, in_exp, in_sign_md, out_ready,
        input  in_ready, out_valid, out_mant, out_cnt, out_exp, out_zero, out_uflow
    );

    modport slave (
        input  in_valid, in_mant, in_exp, in_sign_md, out_ready,
        output in_ready, out_valid, out_mant, out_cnt, out_exp, out_zero, out_uflow
    );

endinterface

// File: rtl/lzc_norm_pipe_lzc_tree.sv
// Combinational leading-zero counter by successive halving; odd widths padded with 1s at the LSB end.
// All-zero input reports cnt = WIDTH.
module lzc_tree
    import lzc_norm_pipe_pkg::*;
#(
    parameter int  WIDTH = 24,
    localparam int CNT_W = cnt_w(WIDTH)
) (
    input  logic [WIDTH-1:0] bits_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             all_zero_o
);
    localparam int L = $clog2(WIDTH);
    localparam int P = 1 << L;

    logic [P-1:0] v;
    logic [L-1:0] cnt;

    // Each step asks whether the upper half of the current window is empty.
    always_comb begin
        v                 = '1;
        v[P-1 -: WIDTH]   = bits_i;
        cnt               = '0;
        for (int k = L - 1; k >= 0; k--) begin
            if ((v >> (P - (1 << k))) == '0) begin
                cnt[k] = 1'b1;
                v      = v << (1 << k);
            end
        end
    end

    assign all_zero_o = ~|bits_i;
    assign cnt_o      = all_zero_o ? CNT_W'(WIDTH) : CNT_W'(cnt);

endmodule

// File: rtl/lzc_norm_pipe.sv
// Two-stage normaliser: S1 counts leading zeros/signs, S2 barrel-shifts and adjusts the exponent.
// Ready propagates combinationally back through both stages; no skid buffer.
module lzc_norm_pipe
    import lzc_norm_pipe_pkg::*;
#(
    parameter int WIDTH = 24,
    parameter int EXP_W = EXP_W_DEF
) (
    input  logic           clk,
    input  logic           rst,
    lzc_norm_pipe_if.slave bus
);
    localparam int CNT_W = cnt_w(WIDTH);

    logic [WIDTH-1:0] tree_in;
    logic [CNT_W-1:0] tree_cnt;
    logic             tree_zero;
    logic             is_sign;

    // Sign mode turns "bits equal to MSB" into zeros and drops the MSB itself.
    assign is_sign = (bus.in_sign_md == LZC_MODE_SIGN);
    assign tree_in = is_sign ? ((bus.in_mant ^ {WIDTH{bus.in_mant[WIDTH-1]}}) << 1) : bus.in_mant;

    lzc_tree #(.WIDTH(WIDTH)) u_tree (
        .bits_i     (tree_in),
        .cnt_o      (tree_cnt),
        .all_zero_o (tree_zero)
    );

    logic             s1_vld_q, s1_vld_d, s1_zero_q, s1_zero_d;
    logic [WIDTH-1:0] s1_mant_q, s1_mant_d;
    logic [EXP_W-1:0] s1_exp_q, s1_exp_d;
    logic [CNT_W-1:0] s1_cnt_q, s1_cnt_d;
    logic             s2_vld_q, s2_vld_d, s2_zero_q, s2_zero_d, s2_uflow_q, s2_uflow_d;
    logic [WIDTH-1:0] s2_mant_q, s2_mant_d;
    logic [EXP_W-1:0] s2_exp_q, s2_exp_d;
    logic [CNT_W-1:0] s2_cnt_q, s2_cnt_d;

    logic             s1_adv, s2_adv;
    logic [WIDTH-1:0] shifted;
    logic [EXP_W:0]   diff;

    assign s2_adv       = !s2_vld_q || bus.out_ready;
    assign s1_adv       = !s1_vld_q || s2_adv;
    assign bus.in_ready = s1_adv;

    always_comb begin
        shifted = s1_mant_q;
        for (int b = 0; b < CNT_W; b++) begin
            if (s1_cnt_q[b]) shifted = shifted << (1 << b);
        end
        diff = {1'b0, s1_exp_q} - (EXP_W + 1)'(s1_cnt_q);
    end

    always_comb begin
        s1_vld_d   = s1_vld_q;
        s1_mant_d  = s1_mant_q;
        s1_exp_d   = s1_exp_q;
        s1_cnt_d   = s1_cnt_q;
        s1_zero_d  = s1_zero_q;
        s2_vld_d   = s2_vld_q;
        s2_mant_d  = s2_mant_q;
        s2_exp_d   = s2_exp_q;
        s2_cnt_d   = s2_cnt_q;
        s2_zero_d  = s2_zero_q;
        s2_uflow_d = s2_uflow_q;
        if (s1_adv) begin
            s1_vld_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_mant_d = bus.in_mant;
                s1_exp_d  = bus.in_exp;
                s1_cnt_d  = (is_sign && tree_cnt > CNT_W'(WIDTH - 1)) ? CNT_W'(WIDTH - 1) : tree_cnt;
                s1_zero_d = tree_zero && (!is_sign || !bus.in_mant[WIDTH-1]);
            end
        end
        if (s2_adv) begin
            s2_vld_d = s1_vld_q;
            if (s1_vld_q) begin
                s2_mant_d  = shifted;
                s2_cnt_d   = s1_cnt_q;
                s2_zero_d  = s1_zero_q;
                // Zero input pins the exponent at 0 without flagging underflow.
                if (s1_zero_q || diff[EXP_W]) begin
                    s2_exp_d   = '0;
                    s2_uflow_d = !s1_zero_q;
                end else begin
                    s2_exp_d   = diff[EXP_W-1:0];
                    s2_uflow_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q   <= 1'b0;
            s1_mant_q  <= '0;
            s1_exp_q   <= '0;
            s1_cnt_q   <= '0;
            s1_zero_q  <= 1'b0;
            s2_vld_q   <= 1'b0;
            s2_mant_q  <= '0;
            s2_exp_q   <= '0;
            s2_cnt_q   <= '0;
            s2_zero_q  <= 1'b0;
            s2_uflow_q <= 1'b0;
        end else begin
            s1_vld_q   <= s1_vld_d;
            s1_mant_q  <= s1_mant_d;
            s1_exp_q   <= s1_exp_d;
            s1_cnt_q   <= s1_cnt_d;
            s1_zero_q  <= s1_zero_d;
            s2_vld_q   <= s2_vld_d;
            s2_mant_q  <= s2_mant_d;
            s2_exp_q   <= s2_exp_d;
            s2_cnt_q   <= s2_cnt_d;
            s2_zero_q  <= s2_zero_d;
            s2_uflow_q <= s2_uflow_d;
        end
    end

    assign bus.out_valid = s2_vld_q;
    assign bus.out_mant  = s2_mant_q;
    assign bus.out_cnt   = s2_cnt_q;
    assign bus.out_exp   = s2_exp_q;
    assign bus.out_zero  = s2_zero_q;
    assign bus.out_uflow = s2_uflow_q;

endmodule

// File: tb/tb_lzc_norm_pipe.sv
// Directed bench for lzc_norm_pipe at WIDTH=24, EXP_W=8 with hand-computed results.
module tb_lzc_norm_pipe;
    localparam int W = 24;
    localparam int E = 8;
    localparam int C = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lzc_norm_pipe_if #(.WIDTH(W), .EXP_W(E)) bus ();

    lzc_norm_pipe #(.WIDTH(W), .EXP_W(E)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [W-1:0] mant;
        logic [C-1:0] cnt;
        logic [E-1:0] exp;
        logic         zero;
        logic         uflow;
        int           acc;
        int           id;
    } exp_t;

    exp_t         exp_q[$];
    exp_t         pend;
    int           n_cmp = 0;
    int           n_bad = 0;
    int           cyc   = 0;
    int           bid   = 0;
    int           rdy_i = 0;
    logic         in_acc = 1'b0;
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_mant;
    logic [C-1:0] prev_cnt;
    logic         chk_lat = 1'b0;
    logic         low_seen = 1'b0;
    logic         rdy_pat = 1'b0;
    logic         rdy_lvl = 1'b1;
    logic [3:0]   pat = 4'b1001;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    // One clock: drive out_ready, check outputs just after the negedge, then advance.
    task automatic cycle();
        exp_t h;
        bus.out_ready = rdy_pat ? pat[rdy_i % 4] : rdy_lvl;
        rdy_i++;
        #1;
        if (prev_stall) begin
            chk("stall_vld",  64'(bus.out_valid), 64'd1);
            chk("stall_mant", 64'(bus.out_mant),  64'(prev_mant));
            chk("stall_cnt",  64'(bus.out_cnt),   64'(prev_cnt));
        end
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out", 64'd1, 64'd0);
            end else begin
                h = exp_q.pop_front();
                chk($sformatf("b%0d_mant",  h.id), 64'(bus.out_mant),  64'(h.mant));
                chk($sformatf("b%0d_cnt",   h.id), 64'(bus.out_cnt),   64'(h.cnt));
                chk($sformatf("b%0d_exp",   h.id), 64'(bus.out_exp),   64'(h.exp));
                chk($sformatf("b%0d_zero",  h.id), 64'(bus.out_zero),  64'(h.zero));
                chk($sformatf("b%0d_uflow", h.id), 64'(bus.out_uflow), 64'(h.uflow));
                if (chk_lat) chk($sformatf("b%0d_latency", h.id), 64'(cyc - h.acc), 64'd2);
            end
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_mant  = bus.out_mant;
        prev_cnt   = bus.out_cnt;
        if (!bus.in_ready) low_seen = 1'b1;
        in_acc = bus.in_valid && bus.in_ready;
        if (in_acc) begin
            pend.acc = cyc;
            exp_q.push_back(pend);
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic send(input logic [W-1:0] m, input logic [E-1:0] e, input logic md,
                        input logic [W-1:0] xm, input int xc, input int xe,
                        input logic xz, input logic xu);
        pend.mant  = xm;
        pend.cnt   = C'(xc);
        pend.exp   = E'(xe);
        pend.zero  = xz;
        pend.uflow = xu;
        pend.id    = bid++;
        bus.in_valid   = 1'b1;
        bus.in_mant    = m;
        bus.in_exp     = e;
        bus.in_sign_md = md;
        in_acc = 1'b0;
        for (int i = 0; i < 50; i++) begin
            cycle();
            if (in_acc) break;
        end
        if (!in_acc) chk("in_accept_timeout", 64'd0, 64'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60; i++) begin
            if (exp_q.size() == 0 && !bus.out_valid) break;
            cycle();
        end
        chk("drain_left", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int stale;
        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_mant    = '0;
        bus.in_exp     = '0;
        bus.in_sign_md = 1'b0;
        bus.out_ready  = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
        chk("rst_out_mant",  64'(bus.out_mant),  64'd0);
        chk("rst_out_cnt",   64'(bus.out_cnt),   64'd0);
        chk("rst_out_exp",   64'(bus.out_exp),   64'd0);
        chk("rst_out_zero",  64'(bus.out_zero),  64'd0);
        chk("rst_out_uflow", 64'(bus.out_uflow), 64'd0);

        // Directed vectors, out_ready held high.
        chk_lat = 1'b1;
        send(24'h000100, 100, 0, 24'h800000, 15, 85, 0, 0);
        send(24'hFFF000,  50, 1, 24'h800000, 11, 39, 0, 0);
        send(24'h000000,  20, 1, 24'h000000, 23,  0, 1, 0);
        send(24'h000001,  10, 0, 24'h800000, 23,  0, 0, 1);
        send(24'h000000,   7, 0, 24'h000000, 24,  0, 1, 0);
        send(24'h000100,  15, 0, 24'h800000, 15,  0, 0, 0);
        send(24'hFFFFFF,  30, 1, 24'h800000, 23,  7, 0, 0);
        send(24'h00F000,  40, 1, 24'h780000,  7, 33, 0, 0);
        send(24'h800001,   5, 0, 24'h800001,  0,  5, 0, 0);
        send(24'hC00000,   3, 1, 24'h800000,  1,  2, 0, 0);
        drain();
        chk_lat = 1'b0;

        // Back-to-back beats with out_ready cycling 1,0,0,1.
        rdy_pat  = 1'b1;
        rdy_i    = 0;
        low_seen = 1'b0;
        send(24'h400000,   9, 0, 24'h800000,  1,   8, 0, 0);
        send(24'h123456, 200, 0, 24'h91A2B0,  3, 197, 0, 0);
        send(24'h0000FF,  16, 0, 24'hFF0000, 16,   0, 0, 0);
        send(24'hFFFF00, 100, 1, 24'h800000, 15,  85, 0, 0);
        send(24'h3FFFFF,   1, 1, 24'h7FFFFE,  1,   0, 0, 0);
        send(24'h000000, 255, 0, 24'h000000, 24,   0, 1, 0);
        send(24'h000003,   2, 1, 24'h600000, 21,   0, 0, 1);
        send(24'hFFFFFE, 128, 1, 24'h800000, 22, 106, 0, 0);
        drain();
        chk("t4_in_ready_dropped", 64'(low_seen), 64'd1);
        rdy_pat = 1'b0;

        // Reset with two beats in flight.
        rdy_lvl = 1'b0;
        send(24'h000100, 100, 0, 24'h800000, 15, 85, 0, 0);
        send(24'h000001,  10, 0, 24'h800000, 23,  0, 0, 1);
        chk("t5_inflight_vld", 64'(bus.out_valid), 64'd1);
        chk("t5_inflight_rdy", 64'(bus.in_ready),  64'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("t5_rst_in_ready",  64'(bus.in_ready),  64'd1);
        exp_q.delete();
        prev_stall = 1'b0;
        rdy_lvl    = 1'b1;
        stale      = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.out_valid) stale++;
            cycle();
        end
        chk("t5_stale_beats", 64'(stale), 64'd0);
        send(24'h400000, 9, 0, 24'h800000, 1, 8, 0, 0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
